// File: rtl/bcd_disp_pkg.sv
// Shared types and seven-segment constants for the BCD counter display.
// Patterns are active-low, bit order gfedcba.
package bcd_disp_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
// Codes above 9 never occur in the counter and decode to blank.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  bcd_t digit,
  input  logic blank,
  output seg_t seg
);

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) seg = SEG_DIGIT[digit];
  end

endmodule

// File: rtl/bcd_counter_display.sv
// DIGITS-digit BCD up/down counter with edge-detected count input and registered
// seven-segment outputs. Define BCD_COUNTER_DISPLAY_LZB_EN for leading-zero blanking.
module bcd_counter_display
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  count,
  input  logic                  up,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  at_max,
  output logic                  at_min
);

  logic                  count_q;
  logic                  step;
  logic                  carry;
  logic                  borrow;
  logic [4*DIGITS-1:0]   inc_value;
  logic [4*DIGITS-1:0]   dec_value;
  logic [4*DIGITS-1:0]   next_value;
  logic [DIGITS-1:0]     blank;
  logic [7*DIGITS-1:0]   seg_next;

  // Reset pattern of the display: the encoding of zero, honouring blanking.
  function automatic logic [7*DIGITS-1:0] seg_reset_pattern();
    logic [7*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = SEG_DIGIT[0];
`ifdef BCD_COUNTER_DISPLAY_LZB_EN
      if (i > 0) r[7*i +: 7] = SEG_BLANK;
`endif
    end
    return r;
  endfunction

  localparam logic [7*DIGITS-1:0] SEG_RESET = seg_reset_pattern();

  assign step = count & ~count_q;

  // Ripple carry/borrow chains; a digit only changes while the chain is still live.
  always_comb begin
    inc_value = value;
    dec_value = value;
    carry     = 1'b1;
    borrow    = 1'b1;
    at_max    = 1'b1;
    at_min    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value[4*i +: 4] == 4'd9) begin
          inc_value[4*i +: 4] = 4'd0;
        end else begin
          inc_value[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
      if (borrow) begin
        if (value[4*i +: 4] == 4'd0) begin
          dec_value[4*i +: 4] = 4'd9;
        end else begin
          dec_value[4*i +: 4] = value[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
      if (value[4*i +: 4] != 4'd9) at_max = 1'b0;
      if (value[4*i +: 4] != 4'd0) at_min = 1'b0;
    end
  end

  // Overflowing the chain wraps naturally; saturation just suppresses the update.
  always_comb begin
    next_value = value;
    if (clear) begin
      next_value = '0;
    end else if (step && up) begin
      if (!(at_max && (WRAP == 0))) next_value = inc_value;
    end else if (step && !up) begin
      if (!(at_min && (WRAP == 0))) next_value = dec_value;
    end
  end

`ifdef BCD_COUNTER_DISPLAY_LZB_EN
  logic zero_above;

  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (value[4*i +: 4] != 4'd0) zero_above = 1'b0;
      blank[i] = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_to_seg u_bcd_to_seg (
      .digit (value[4*i +: 4]),
      .blank (blank[i]),
      .seg   (seg_next[7*i +: 7])
    );
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 1'b0;
      value   <= '0;
      seg     <= SEG_RESET;
    end else begin
      count_q <= count;
      value   <= next_value;
      seg     <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Self-checking bench: a WRAP=0 and a WRAP=1 counter share stimulus and are compared
// against an integer-arithmetic reference model.
module tb_bcd_counter_display;

  localparam int DIGITS = 2;
  localparam int MAXV   = 99;

  logic clk;
  logic reset;
  logic count;
  logic up;
  logic clear;

  logic [4*DIGITS-1:0] val_w [0:1];
  logic [7*DIGITS-1:0] seg_w [0:1];
  logic                max_w [0:1];
  logic                min_w [0:1];

  int   m_val [0:1];
  int   m_seg [0:1];
  logic m_cq;

  int errors = 0;
  int checks = 0;

  bcd_counter_display #(.DIGITS(DIGITS), .WRAP(0)) dut_w0 (
    .clk(clk), .reset(reset), .count(count), .up(up), .clear(clear),
    .value(val_w[0]), .seg(seg_w[0]), .at_max(max_w[0]), .at_min(min_w[0])
  );

  bcd_counter_display #(.DIGITS(DIGITS), .WRAP(1)) dut_w1 (
    .clk(clk), .reset(reset), .count(count), .up(up), .clear(clear),
    .value(val_w[1]), .seg(seg_w[1]), .at_max(max_w[1]), .at_min(min_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(int v);
    logic [4*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_seg(int v);
    logic [7*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[7*i +: 7] = seg_of((v / (10 ** i)) % 10);
`ifdef BCD_COUNTER_DISPLAY_LZB_EN
      if ((i > 0) && ((v / (10 ** i)) == 0)) r[7*i +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction

  // One clock with the given inputs; the model advances on the same edge as the DUT.
  task automatic cycle(input logic c, input logic u, input logic clr);
    logic stp;
    count = c;
    up    = u;
    clear = clr;
    @(posedge clk);
    stp = c && !m_cq;
    for (int k = 0; k < 2; k++) begin
      m_seg[k] = m_val[k];
      if (clr) m_val[k] = 0;
      else if (stp && u) m_val[k] = (m_val[k] == MAXV) ? ((k == 1) ? 0 : MAXV) : m_val[k] + 1;
      else if (stp && !u) m_val[k] = (m_val[k] == 0) ? ((k == 1) ? MAXV : 0) : m_val[k] - 1;
    end
    m_cq = c;
    #1;
  endtask

  task automatic pulse(input logic u, input int n);
    for (int j = 0; j < n; j++) begin
      cycle(1'b1, u, 1'b0);
      cycle(1'b0, u, 1'b0);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0;
      m_seg[k] = 0;
    end
    m_cq = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; count = 1'b0; up = 1'b1; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_w[k] !== 8'h00) begin errors++; $display("FAIL reset_value w%0d: got %h want 00", k, val_w[k]); end
      checks++;
      if (seg_w[k] !== exp_seg(0)) begin errors++; $display("FAIL reset_seg w%0d: got %b want %b", k, seg_w[k], exp_seg(0)); end
      checks++;
      if (min_w[k] !== 1'b1 || max_w[k] !== 1'b0) begin
        errors++; $display("FAIL reset_flags w%0d: got min=%b max=%b want min=1 max=0", k, min_w[k], max_w[k]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_count_up();
    pulse(1'b1, 10);
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_w[k] !== 8'h11) begin errors++; $display("FAIL up11_value w%0d: got %h want 11", k, val_w[k]); end
      checks++;
      if (seg_w[k] !== exp_seg(10)) begin errors++; $display("FAIL up11_seg_lag w%0d: got %b want %b", k, seg_w[k], exp_seg(10)); end
    end
    cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (seg_w[k] !== exp_seg(11)) begin errors++; $display("FAIL up11_seg w%0d: got %b want %b", k, seg_w[k], exp_seg(11)); end
    end
    repeat (5) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_w[k] !== 8'h12) begin errors++; $display("FAIL hold_high w%0d: got %h want 12", k, val_w[k]); end
    end
  endtask

  task automatic test_boundary_max();
    pulse(1'b1, 87);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_w[k] !== 8'h99 || max_w[k] !== 1'b1 || min_w[k] !== 1'b0) begin
        errors++; $display("FAIL load99 w%0d: got %h max=%b min=%b want 99 max=1 min=0", k, val_w[k], max_w[k], min_w[k]);
      end
    end
    pulse(1'b1, 1);
    checks++;
    if (val_w[1] !== 8'h00) begin errors++; $display("FAIL wrap_up w1: got %h want 00", val_w[1]); end
    checks++;
    if (val_w[0] !== 8'h99 || max_w[0] !== 1'b1) begin
      errors++; $display("FAIL sat_up w0: got %h max=%b want 99 max=1", val_w[0], max_w[0]);
    end
  endtask

  task automatic test_boundary_min();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1);
    checks++;
    if (val_w[1] !== 8'h99 || max_w[1] !== 1'b1) begin
      errors++; $display("FAIL wrap_down w1: got %h max=%b want 99 max=1", val_w[1], max_w[1]);
    end
    checks++;
    if (val_w[0] !== 8'h00 || min_w[0] !== 1'b1) begin
      errors++; $display("FAIL sat_down w0: got %h min=%b want 00 min=1", val_w[0], min_w[0]);
    end
  endtask

  task automatic test_borrow();
    cycle(1'b0, 1'b1, 1'b1);
    pulse(1'b1, 10);
    pulse(1'b0, 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_w[k] !== 8'h09) begin errors++; $display("FAIL borrow w%0d: got %h want 09", k, val_w[k]); end
      checks++;
      if (seg_w[k] !== exp_seg(9)) begin errors++; $display("FAIL borrow_seg w%0d: got %b want %b", k, seg_w[k], exp_seg(9)); end
    end
  endtask

  task automatic test_clear_step();
    cycle(1'b0, 1'b1, 1'b1);
    pulse(1'b1, 5);
    cycle(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_w[k] !== 8'h00) begin errors++; $display("FAIL clear_wins w%0d: got %h want 00", k, val_w[k]); end
    end
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_w[k] !== 8'h00 || seg_w[k] !== exp_seg(0)) begin
        errors++; $display("FAIL no_deferred_step w%0d: got %h seg=%b want 00 seg=%b", k, val_w[k], seg_w[k], exp_seg(0));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (val_w[k] !== to_bcd(m_val[k]) || seg_w[k] !== exp_seg(m_seg[k]) ||
            max_w[k] !== (m_val[k] == MAXV) || min_w[k] !== (m_val[k] == 0)) begin
          errors++;
          $display("FAIL random[%0d] w%0d: got val=%h seg=%b max=%b min=%b want val=%h seg=%b max=%b min=%b",
                   n, k, val_w[k], seg_w[k], max_w[k], min_w[k], to_bcd(m_val[k]), exp_seg(m_seg[k]),
                   (m_val[k] == MAXV), (m_val[k] == 0));
        end
      end
    end
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    pulse(1'b1, 3);
    cycle(1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_w[k] !== 8'h00 || seg_w[k] !== exp_seg(0) || min_w[k] !== 1'b1) begin
        errors++; $display("FAIL async_reset w%0d: got %h seg=%b min=%b want 00 seg=%b min=1", k, val_w[k], seg_w[k], min_w[k], exp_seg(0));
      end
    end
    reset = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (val_w[k] !== to_bcd(m_val[k]) || val_w[k] !== 8'h01) begin
        errors++; $display("FAIL release_high w%0d: got %h want 01", k, val_w[k]);
      end
    end
    cycle(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_boundary_max();
    test_boundary_min();
    test_borrow();
    test_clear_step();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_counter_display.md
# bcd_counter_display

Parametrised multi-digit BCD up/down counter with registered seven-segment outputs for the DE1-SoC HEX displays. It generalises the fixed two-digit, 4-bit display counter to DIGITS decimal digits, with a direction input, a synchronous clear, a selectable wrap or saturate mode and an edge-detected count input. It sits between user inputs (debounced keys or switches) and the HEX pins.

## Interface
Parameters:
- DIGITS, default 2: number of decimal digits, 1..6.
- WRAP, default 1: 1 = wrap at the boundaries; 0 = saturate at the boundaries.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- count  input  1  count request; one step per rising edge of this input.
- up  input  1  direction for the step: 1 = increment, 0 = decrement.
- clear  input  1  synchronous clear to zero.
- value  output  4*DIGITS  BCD count; digit i is value[4i+3:4i], and digit 0 is the least significant.
- seg  output  7*DIGITS  active-low segment patterns; seg[7i+6:7i] drives digit i; bit order gfedcba.
- at_max  output  1  high when every digit of value is 9.
- at_min  output  1  high when value is zero.

## Operation
Count edge detection:
- count_q is a register that holds the previous count; it resets to 0.
- step = count & ~count_q.
- A count held high produces exactly one step.

Priority at each clock edge:
1. clear: value becomes 0.
2. step with up=1: increment.
3. step with up=0: decrement.
4. Otherwise: hold.

BCD arithmetic:
- Each digit stays within 0..9 at all times.
- Increment: a digit at 9 becomes 0 and carries into the next digit.
- Decrement: a digit at 0 becomes 9 and borrows from the next digit.

Boundaries:
- Increment at all-9s: WRAP=1 gives all zeros; WRAP=0 holds the value.
- Decrement at zero: WRAP=1 gives all 9s; WRAP=0 holds the value.

Flags:
- at_max and at_min are combinational from value.
- For a single value, at most one of the two flags is high.

Segment encoding, active-low gfedcba:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- blank=1111111

## Timing
- Reset, asynchronous: value=0, count_q=0.
- seg reset value: every digit shows "0" (1000000), except as modified by the Configuration macro.
- Flags during reset: at_min=1, at_max=0.
- Latency to value: value updates on the same clock edge on which step is sampled high.
- Latency to seg: seg is registered from value and lags value by one cycle.
- Clear latency: clear affects value on that edge and seg one edge later.
- Clear together with step: clear wins and the step is discarded.
- The edge detector still updates count_q on that cycle, so no deferred step fires afterwards.
- Reset asserted mid-operation: all registers clear immediately, without waiting for a clock edge.
- Reset release: the first step requires a rising edge of count that occurs after the release. If count is already high when reset releases, that counts as a rising edge, because count_q=0.

## Configuration
- Macro: `BCD_COUNTER_DISPLAY_LZB_EN`, leading-zero blanking.
- Defined:
  - A digit i>0 is blank when it and every higher digit are 0.
  - Digit 0 is never blanked.
  - Reset value of seg: digit 0 shows "0" and all other digits are blank.
- Undefined: every digit always shows its numeral, and the blanking logic is absent from the netlist.

## Structure
Package bcd_disp_pkg:
- typedef logic [3:0] bcd_t.
- typedef logic [6:0] seg_t.
- Constants SEG_DIGIT[0:9] and SEG_BLANK.

Sub-module bcd_to_seg:
- Purely combinational: input bcd_t plus a blank flag, output seg_t.
- Instantiated DIGITS times in a generate loop.

The top level holds:
- the edge detector;
- the carry/borrow chain;
- the seg registers.

## Test plan
- Reset, with DIGITS=2 and WRAP=1: value=0x00, every segment pattern =1000000, at_min=1. With the macro, digit 1 =1111111.
- Pulse count 11 times with up=1: value=0x11 and seg shows 0x11 one cycle later. Hold count high for 5 cycles: exactly one increment.
- Load 0x99 by counting, then one up pulse: WRAP=1 gives 0x00; WRAP=0 holds 0x99 with at_max=1.
- From 0x00 with up=0, one pulse: WRAP=1 gives 0x99; WRAP=0 holds 0x00 with at_min=1.
- From 0x10, one down pulse: value=0x09 (borrow), and digit 1 is blank when the macro is defined.
- clear and a count rising edge in the same cycle from 0x05: value=0x00 and no later increment. Reset asserted asynchronously mid-count: value=0 before the next clock edge.
